// File: rtl/tod_pkg.sv
// Shared widths, constants and state/correction encodings for the PPS-to-ToD steering logic.
package tod_pkg;

  localparam int TOD_SUB_W  = 20;
  localparam int TOD_NS_W   = 32;
  localparam int TOD_SEC_W  = 48;
  localparam int NS_PER_SEC = 1000000000;
  localparam int ERR_W      = TOD_SUB_W + TOD_NS_W + 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_APPLY
  } tod_state_e;

  typedef enum logic [1:0] {
    CORR_NONE,
    CORR_OFFSET,
    CORR_INIT
  } tod_corr_e;

  // Signed error spans +/-2 s of fixed-point time plus a sign bit.
  function automatic int err_width(input int sub_w, input int ns_w);
    return sub_w + ns_w + 2;
  endfunction

endpackage

// File: rtl/tod_pps_edge.sv
// Two-flop synchroniser for the asynchronous PPS input followed by a rising-edge detector.
module tod_pps_edge
  import tod_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic pps_in,
  output logic pps_det
);

  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[1:0], pps_in};
  end

  assign pps_det = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/tod_pps_sync.sv
// Measures local time against the PPS reference and steers the ToD counter by offset or reload.
module tod_pps_sync
  import tod_pkg::*;
#(
  parameter int TIME_WIDTH_SUB_NS = TOD_SUB_W,
  parameter int TIME_WIDTH_NS     = TOD_NS_W,
  parameter int TIME_WIDTH_SEC    = TOD_SEC_W,
  parameter int LAT_NS            = 0,
  parameter int INIT_NS_COMP      = 0,
  parameter int DEADBAND_NS       = 2,
  parameter int LOCK_CNT          = 4,
  parameter int PPS_TIMEOUT       = 200000000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         pps_in,
  input  logic                         ref_valid,
  output logic                         ref_ready,
  input  logic [TIME_WIDTH_SEC-1:0]    ref_sec,
  input  logic [TIME_WIDTH_SUB_NS-1:0] time_sub_ns,
  input  logic [TIME_WIDTH_NS-1:0]     time_ns,
  input  logic [TIME_WIDTH_SEC-1:0]    time_sec,
  output logic                         set_init_time,
  output logic [TIME_WIDTH_SUB_NS-1:0] init_time_sub_ns,
  output logic [TIME_WIDTH_NS-1:0]     init_time_ns,
  output logic [TIME_WIDTH_SEC-1:0]    init_time_sec,
  output logic                         set_offset_time,
  output logic                         plus_offset_time,
  output logic [TIME_WIDTH_SUB_NS-1:0] offset_time_sub_ns,
  output logic [TIME_WIDTH_NS-1:0]     offset_time_ns,
  output logic                         locked,
  output logic                         holdover,
  output logic                         missed_ref
);

  localparam int EW   = err_width(TIME_WIDTH_SUB_NS, TIME_WIDTH_NS);
  localparam int TO_W = $clog2(PPS_TIMEOUT + 1);
  localparam int LK_W = $clog2(LOCK_CNT + 1);
  localparam int SDW  = TIME_WIDTH_SEC + 1;

  localparam logic signed [EW-1:0]  NSPS      = EW'(NS_PER_SEC);
  localparam logic signed [EW-1:0]  ONE_SEC_E = NSPS <<< TIME_WIDTH_SUB_NS;
  localparam logic signed [EW-1:0]  DB_E      = EW'(DEADBAND_NS) <<< TIME_WIDTH_SUB_NS;
  localparam logic signed [EW-1:0]  E_MAX     = {1'b0, {(EW-1){1'b1}}};
  localparam logic signed [SDW-1:0] SD_ONE    = SDW'(1);
  localparam logic [TO_W-1:0]       TO_MAX    = TO_W'(PPS_TIMEOUT);
  localparam logic [LK_W-1:0]       LK_MAX    = LK_W'(LOCK_CNT);

  // Any second difference beyond +/-1 is pinned well past the reload threshold.
  function automatic logic signed [EW-1:0] sat_err(
    input logic signed [SDW-1:0]         sec_d,
    input logic [TIME_WIDTH_NS-1:0]      ns,
    input logic [TIME_WIDTH_SUB_NS-1:0]  sub
  );
    logic signed [EW-1:0] sd;
    logic signed [EW-1:0] v;
    sd = EW'(sec_d);
    v  = sd * NSPS + EW'(LAT_NS) - $signed(EW'(ns));
    if (sec_d > SD_ONE)       sat_err = E_MAX;
    else if (sec_d < -SD_ONE) sat_err = -E_MAX;
    else                      sat_err = (v <<< TIME_WIDTH_SUB_NS) - $signed(EW'(sub));
  endfunction

  function automatic logic signed [EW-1:0] abs_err(input logic signed [EW-1:0] e);
    abs_err = (e < 0) ? -e : e;
  endfunction

  tod_state_e state, state_nxt;
  tod_corr_e  corr_p1, corr_p2;

  logic                         pps_det, cap_en, miss, glitch, vld_p1, vld_p2, to_hit;
  logic                         ref_held;
  logic [TIME_WIDTH_SEC-1:0]    ref_reg;
  logic [TIME_WIDTH_SEC-1:0]    cap_sec_p0;
  logic [TIME_WIDTH_NS-1:0]     cap_ns_p0;
  logic [TIME_WIDTH_SUB_NS-1:0] cap_sub_p0;
  logic signed [SDW-1:0]        sec_d_p1;
  logic signed [EW-1:0]         err_p1, abs_p1;
  logic [LK_W-1:0]              lock_cnt;
  logic [TO_W-1:0]              to_cnt;
  logic [15:0]                  glitch_cnt;

  tod_pps_edge u_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .pps_in  (pps_in),
    .pps_det (pps_det)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (pps_det && ref_held) state_nxt = ST_CALC;
      ST_CALC:  state_nxt = ST_APPLY;
      ST_APPLY: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cap_en          = (state == ST_IDLE) && pps_det && ref_held;
    miss            = (state == ST_IDLE) && pps_det && !ref_held;
    glitch          = (state != ST_IDLE) && pps_det;
    vld_p1          = (state == ST_CALC);
    vld_p2          = (state == ST_APPLY);
    set_init_time   = vld_p2 && (corr_p2 == CORR_INIT);
    set_offset_time = vld_p2 && (corr_p2 == CORR_OFFSET);
  end

  assign ref_ready = ~ref_held;

  // Stage p0: capture local time and buffer the reference second.
  always_ff @(posedge clk) begin
    if (cap_en) begin
      cap_sec_p0 <= time_sec;
      cap_ns_p0  <= time_ns;
      cap_sub_p0 <= time_sub_ns;
    end
    if (ref_valid && ref_ready) ref_reg <= ref_sec;
  end

  // Stage p1: signed error and correction class.
  always_comb begin
    sec_d_p1 = $signed({1'b0, ref_reg}) - $signed({1'b0, cap_sec_p0});
    err_p1   = sat_err(sec_d_p1, cap_ns_p0, cap_sub_p0);
    abs_p1   = abs_err(err_p1);
    if (abs_p1 >= ONE_SEC_E) corr_p1 = CORR_INIT;
    else if (abs_p1 >= DB_E) corr_p1 = CORR_OFFSET;
    else                     corr_p1 = CORR_NONE;
  end

  assign to_hit = !pps_det && (to_cnt == TO_MAX - TO_W'(1));

  // Stage p2: register correction values, lock and holdover status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_held           <= 1'b0;
      corr_p2            <= CORR_NONE;
      init_time_sec      <= '0;
      init_time_ns       <= '0;
      init_time_sub_ns   <= '0;
      plus_offset_time   <= 1'b0;
      offset_time_ns     <= '0;
      offset_time_sub_ns <= '0;
      lock_cnt           <= '0;
      locked             <= 1'b0;
      to_cnt             <= '0;
      holdover           <= 1'b0;
      missed_ref         <= 1'b0;
      glitch_cnt         <= '0;
    end else begin
      if (ref_valid && ref_ready) ref_held <= 1'b1;
      else if (vld_p1)            ref_held <= 1'b0;

      if (vld_p1) begin
        corr_p2 <= corr_p1;
        if (corr_p1 == CORR_INIT) begin
          init_time_sec    <= ref_reg;
          init_time_ns     <= TIME_WIDTH_NS'(INIT_NS_COMP);
          init_time_sub_ns <= '0;
        end
        if (corr_p1 == CORR_OFFSET) begin
          plus_offset_time   <= (err_p1 > 0);
          offset_time_ns     <= TIME_WIDTH_NS'(abs_p1 >>> TIME_WIDTH_SUB_NS);
          offset_time_sub_ns <= abs_p1[TIME_WIDTH_SUB_NS-1:0];
        end
      end

      missed_ref <= miss;
      if (glitch) glitch_cnt <= glitch_cnt + 16'd1;

      if (miss || (vld_p1 && corr_p1 != CORR_NONE)) begin
        lock_cnt <= '0;
        locked   <= 1'b0;
      end else if (vld_p1) begin
        if (lock_cnt != LK_MAX) lock_cnt <= lock_cnt + LK_W'(1);
        locked <= (lock_cnt >= LK_MAX - LK_W'(1));
      end

      if (pps_det)               to_cnt <= '0;
      else if (to_cnt != TO_MAX) to_cnt <= to_cnt + TO_W'(1);

      if (pps_det)     holdover <= 1'b0;
      else if (to_hit) holdover <= 1'b1;

      // Losing PPS overrides any lock progress in the same cycle.
      if (to_hit) begin
        lock_cnt <= '0;
        locked   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tod_pps_sync.sv
// Randomized self-checking bench for tod_pps_sync against a behavioural time-error model.
module tb_tod_pps_sync;

  localparam longint SUB_SCALE = 64'sd1048576;
  localparam longint ONE_S_E   = 64'sd1000000000 * SUB_SCALE;
  localparam longint DB_E      = 64'sd2 * SUB_SCALE;
  localparam int     LOCK_N    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pps_in = 1'b0;
  logic        ref_valid = 1'b0;
  logic        ref_ready;
  logic [47:0] ref_sec = '0;
  logic [19:0] time_sub_ns = '0;
  logic [31:0] time_ns = '0;
  logic [47:0] time_sec = '0;
  logic        set_init_time, set_offset_time, plus_offset_time;
  logic [19:0] init_time_sub_ns, offset_time_sub_ns;
  logic [31:0] init_time_ns, offset_time_ns;
  logic [47:0] init_time_sec;
  logic        locked, holdover, missed_ref;

  int n_cmp = 0;
  int n_bad = 0;

  int     m_lock = 0;
  bit     m_locked = 0, m_plus = 0, m_hold = 0;
  longint m_off_ns = 0, m_off_sub = 0, m_init_sec = 0, m_init_ns = 0, m_init_sub = 0;

  tod_pps_sync #(
    .LOCK_CNT    (LOCK_N),
    .PPS_TIMEOUT (100)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .pps_in             (pps_in),
    .ref_valid          (ref_valid),
    .ref_ready          (ref_ready),
    .ref_sec            (ref_sec),
    .time_sub_ns        (time_sub_ns),
    .time_ns            (time_ns),
    .time_sec           (time_sec),
    .set_init_time      (set_init_time),
    .init_time_sub_ns   (init_time_sub_ns),
    .init_time_ns       (init_time_ns),
    .init_time_sec      (init_time_sec),
    .set_offset_time    (set_offset_time),
    .plus_offset_time   (plus_offset_time),
    .offset_time_sub_ns (offset_time_sub_ns),
    .offset_time_ns     (offset_time_ns),
    .locked             (locked),
    .holdover           (holdover),
    .missed_ref         (missed_ref)
  );

  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_set_init"}, set_init_time, 0);
    check({tag, "_set_offset"}, set_offset_time, 0);
    check({tag, "_plus"}, plus_offset_time, 0);
    check({tag, "_off_ns"}, offset_time_ns, 0);
    check({tag, "_off_sub"}, offset_time_sub_ns, 0);
    check({tag, "_init_sec"}, init_time_sec, 0);
    check({tag, "_init_ns"}, init_time_ns, 0);
    check({tag, "_init_sub"}, init_time_sub_ns, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_holdover"}, holdover, 0);
    check({tag, "_missed"}, missed_ref, 0);
    check({tag, "_ref_ready"}, ref_ready, 1);
  endtask

  task automatic give_ref(input logic [47:0] r);
    bit ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (ref_ready) ok = 1;
    end
    check("ref_ready_wait", ok, 1);
    ref_valid = 1'b1;
    ref_sec   = r;
    @(posedge clk); #1;
    ref_valid = 1'b0;
    check("ref_ready_drop", ref_ready, 0);
  endtask

  // Model: error from the reference rules, then the resulting command and lock state.
  task automatic pps_event(input bit with_ref, input logic [47:0] r, input logic [47:0] s,
                           input logic [31:0] ns, input logic [19:0] sub);
    int     cls = 0;
    longint d, e, ae;
    bit     old_locked, new_locked, mh;
    if (with_ref) give_ref(r);
    old_locked = m_locked;
    if (with_ref) begin
      d = longint'(r) - longint'(s);
      e = 0;
      if (d > 1 || d < -1) cls = 2;
      else begin
        e  = (d * 1000000000 - longint'(ns)) * SUB_SCALE - longint'(sub);
        ae = (e < 0) ? -e : e;
        cls = (ae >= ONE_S_E) ? 2 : (ae >= DB_E) ? 1 : 0;
      end
      if (cls == 2) begin
        m_init_sec = longint'(r); m_init_ns = 0; m_init_sub = 0;
        m_lock = 0;
      end else if (cls == 1) begin
        m_plus = (e > 0); m_off_ns = ae / SUB_SCALE; m_off_sub = ae % SUB_SCALE;
        m_lock = 0;
      end else if (m_lock < LOCK_N) m_lock++;
    end else m_lock = 0;
    m_locked   = (m_lock == LOCK_N);
    new_locked = m_locked;
    mh         = m_hold;
    m_hold     = 0;

    @(negedge clk);
    time_sec = s; time_ns = ns; time_sub_ns = sub;
    pps_in = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      check("set_init", set_init_time, (i == 4 && cls == 2));
      check("set_offset", set_offset_time, (i == 4 && cls == 1));
      check("missed_ref", missed_ref, (i == 3 && !with_ref));
      check("locked", locked, (i >= (with_ref ? 4 : 3)) ? new_locked : old_locked);
      check("holdover", holdover, (mh && i < 3));
      if (i == 3) check("ref_ready_c1", ref_ready, !with_ref);
      if (i == 5) begin
        check("ref_ready_after", ref_ready, 1);
        check("plus", plus_offset_time, m_plus);
        check("off_ns", offset_time_ns, m_off_ns);
        check("off_sub", offset_time_sub_ns, m_off_sub);
        check("init_sec", init_time_sec, m_init_sec);
        check("init_ns", init_time_ns, m_init_ns);
        check("init_sub", init_time_sub_ns, m_init_sub);
      end
      if (i == 4) pps_in = 1'b0;
    end
  endtask

  initial begin
    logic [47:0] r, s;
    logic [31:0] ns;
    logic [19:0] sub;
    int          cat;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("rst_rel");

    pps_event(1, 48'd5, 48'd5, 32'd0, 20'h80000);
    pps_event(1, 48'd5, 48'd5, 32'd100, 20'd0);
    pps_event(1, 48'd5, 48'd4, 32'd999999900, 20'd0);
    pps_event(1, 48'd5, 48'd3, 32'd0, 20'd0);
    for (int k = 0; k < 4; k++) pps_event(1, 48'(10 + k), 48'(10 + k), 32'd0, 20'd0);
    pps_event(0, 48'd0, 48'd20, 32'd0, 20'd0);

    for (int n = 0; n < 40; n++) begin
      r   = 48'(100 + $urandom_range(0, 1000000));
      cat = $urandom_range(0, 5);
      ns  = $urandom_range(0, 999999999);
      sub = 20'($urandom);
      case (cat)
        0, 1: begin s = r; ns = 0; sub = 20'($urandom_range(0, 1048575)); end
        2:    begin s = r - 48'd1; ns = 32'd999999999; end
        3:    s = ($urandom_range(0, 1) != 0) ? r : r - 48'd1;
        default: s = ($urandom_range(0, 1) != 0) ? r + 48'($urandom_range(2, 5))
                                                 : r - 48'($urandom_range(2, 5));
      endcase
      pps_event($urandom_range(0, 7) != 0, r, s, ns, sub);
    end

    repeat (50) @(posedge clk);
    #1;
    check("holdover_early", holdover, 0);
    repeat (60) @(posedge clk);
    #1;
    check("holdover_set", holdover, 1);
    check("holdover_locked", locked, 0);
    m_hold = 1; m_lock = 0; m_locked = 0;
    pps_event(1, 48'd50, 48'd50, 32'd0, 20'd0);

    give_ref(48'd60);
    @(negedge clk);
    time_sec = 48'd57; time_ns = 32'd12345; time_sub_ns = 20'd0;
    pps_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_calc");
    @(negedge clk);
    rst_n  = 1'b1;
    pps_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_reset_outputs("rst_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
